uart_top: RTL and testbench

UART_TOP -- requirements
Module: uart_top

---
 rtl/uart_top.sv | 337 +++++++++++++++++++++++++++++++++
 tb/tb_uart_top.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_top.sv
// rtl/uart_top.sv - UART transceiver with TX/RX FIFOs and internal loopback
//
// uart_fifo: synchronous FIFO, registered status pulses, combinational head.
//   clk, rst_n            clock, synchronous active-low reset
//   wr_en, wr_data        write strobe and data
//   rd_en, head           read strobe, current head entry
//   full, almost_full     count == DEPTH, count == DEPTH-1
//   empty, almost_empty   count == 0, count == 1
//   overflow, underflow   one-cycle pulse on write-when-full / read-when-empty
//   wr_ack                one-cycle pulse on accepted write
//
// uart_top: 8N1 / 8E1 / 8O1 UART.
//   clk, rst_n            clock, synchronous active-low reset
//   baud_divisor          clk cycles per bit, clamped to a minimum of 16
//   i_parity_type         00/11 none, 01 even, 10 odd
//   i_data_in, i_wr_en    TX FIFO write port
//   i_full .. i_wr_ack    TX FIFO status
//   o_fifo_rd_en          RX FIFO read strobe
//   o_fifo_data_out       RX FIFO read data (registered on accepted read)
//   o_empty .. o_wr_ack   RX FIFO status
//   o_framing_error       stop bit sampled low on the last frame
//   o_parity_error        parity mismatch on the last frame
//   o_overrun_error       sticky: a received byte was dropped on a full RX FIFO
//   baud_tick_o           TX bit-period tick
//   i_rx, o_tx            serial input / output, idle high

module uart_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] head,
    output logic         full,
    output logic         almost_full,
    output logic         empty,
    output logic         almost_empty,
    output logic         overflow,
    output logic         underflow,
    output logic         wr_ack
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_wr;
    logic          do_rd;

    assign do_wr        = wr_en && !full;
    assign do_rd        = rd_en && !empty;
    assign head         = mem[rd_ptr];
    assign full         = (count == CW'(DEPTH));
    assign almost_full  = (count == CW'(DEPTH - 1));
    assign empty        = (count == '0);
    assign almost_empty = (count == CW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            wr_ack    <= 1'b0;
        end else begin
            wr_ack    <= do_wr;
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end
endmodule

module uart_top #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       baud_divisor,
    input  logic [1:0]        i_parity_type,
    input  logic [DATA_W-1:0] i_data_in,
    input  logic              i_wr_en,
    output logic              i_full,
    output logic              i_almostfull,
    output logic              i_almostempty,
    output logic              i_overflow,
    output logic              i_underflow,
    output logic              i_wr_ack,
    input  logic              o_fifo_rd_en,
    output logic [DATA_W-1:0] o_fifo_data_out,
    output logic              o_empty,
    output logic              o_almostfull,
    output logic              o_almostempty,
    output logic              o_overflow,
    output logic              o_underflow,
    output logic              o_wr_ack,
    output logic              o_framing_error,
    output logic              o_parity_error,
    output logic              o_overrun_error,
    output logic              baud_tick_o,
    input  logic              i_rx,
    output logic              o_tx
);
    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b010,
        PARITY = 3'b011,
        STOP   = 3'b100
    } state_t;

    localparam int BW = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    logic [15:0] div_eff;
    logic [15:0] div_m1;
    logic [15:0] half_m1;
    logic        parity_en;
    logic        parity_odd;

    assign div_eff    = (baud_divisor < 16'd16) ? 16'd16 : baud_divisor;
    assign div_m1     = div_eff - 16'd1;
    assign half_m1    = (div_eff >> 1) - 16'd1;
    assign parity_en  = (i_parity_type == 2'b01) || (i_parity_type == 2'b10);
    assign parity_odd = (i_parity_type == 2'b10);

    // ---------------- TX ----------------
    state_t              tx_state;
    logic [15:0]         tx_cnt;
    logic [DATA_W-1:0]   tx_shift;
    logic [BW-1:0]       tx_bit;
    logic                tx_par;
    logic [DATA_W-1:0]   tx_head;
    logic                tx_empty;
    logic                tx_pop;

    assign baud_tick_o = (tx_cnt == div_m1);
    assign tx_pop      = baud_tick_o && (tx_state == IDLE) && !tx_empty;

    uart_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (i_wr_en),
        .wr_data      (i_data_in),
        .rd_en        (tx_pop),
        .head         (tx_head),
        .full         (i_full),
        .almost_full  (i_almostfull),
        .empty        (tx_empty),
        .almost_empty (i_almostempty),
        .overflow     (i_overflow),
        .underflow    (i_underflow),
        .wr_ack       (i_wr_ack)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_shift <= '0;
            tx_bit   <= '0;
            tx_par   <= 1'b0;
            o_tx     <= 1'b1;
        end else begin
            // >= rather than == so a divisor lowered mid-count still wraps.
            if (tx_cnt >= div_m1) tx_cnt <= '0;
            else                  tx_cnt <= tx_cnt + 16'd1;

            if (baud_tick_o) begin
                case (tx_state)
                    IDLE: begin
                        if (!tx_empty) begin
                            tx_shift <= tx_head;
                            tx_par   <= (^tx_head) ^ parity_odd;
                            o_tx     <= 1'b0;
                            tx_state <= START;
                        end
                    end
                    START: begin
                        o_tx     <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= '0;
                        tx_state <= DATA;
                    end
                    DATA: begin
                        if (tx_bit == LAST_BIT) begin
                            if (parity_en) begin
                                o_tx     <= tx_par;
                                tx_state <= PARITY;
                            end else begin
                                o_tx     <= 1'b1;
                                tx_state <= STOP;
                            end
                        end else begin
                            o_tx     <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                            tx_bit   <= tx_bit + BW'(1);
                        end
                    end
                    PARITY: begin
                        o_tx     <= 1'b1;
                        tx_state <= STOP;
                    end
                    default: begin
                        o_tx     <= 1'b1;
                        tx_state <= IDLE;
                    end
                endcase
            end
        end
    end

    // ---------------- RX ----------------
    // i_rx is assumed already synchronous to clk. ANDing with o_tx loops TX
    // back while the external line idles high.
    logic                rx;
    logic                rx_d;
    state_t              rx_state;
    logic [15:0]         rx_cnt;
    logic [DATA_W-1:0]   rx_shift;
    logic [BW-1:0]       rx_bit;
    logic                rx_par;
    logic                rx_wr;
    logic                rx_full;
    logic [DATA_W-1:0]   rx_head;

    assign rx    = i_rx & o_tx;
    assign rx_wr = (rx_state == STOP) && (rx_cnt >= div_m1);

    uart_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (rx_wr),
        .wr_data      (rx_shift),
        .rd_en        (o_fifo_rd_en),
        .head         (rx_head),
        .full         (rx_full),
        .almost_full  (o_almostfull),
        .empty        (o_empty),
        .almost_empty (o_almostempty),
        .overflow     (o_overflow),
        .underflow    (o_underflow),
        .wr_ack       (o_wr_ack)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_d            <= 1'b1;
            rx_state        <= IDLE;
            rx_cnt          <= '0;
            rx_shift        <= '0;
            rx_bit          <= '0;
            rx_par          <= 1'b0;
            o_framing_error <= 1'b0;
            o_parity_error  <= 1'b0;
            o_overrun_error <= 1'b0;
        end else begin
            rx_d <= rx;
            case (rx_state)
                IDLE: begin
                    if (rx_d && !rx) begin
                        rx_cnt   <= '0;
                        rx_state <= START;
                    end
                end
                START: begin
                    // Half a bit in: a start bit that is no longer low was a glitch.
                    if (rx_cnt >= half_m1) begin
                        rx_cnt <= '0;
                        if (!rx) begin
                            rx_bit   <= '0;
                            rx_state <= DATA;
                        end else begin
                            rx_state <= IDLE;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (rx_cnt >= div_m1) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx, rx_shift[DATA_W-1:1]};
                        if (rx_bit == LAST_BIT) rx_state <= parity_en ? PARITY : STOP;
                        else                    rx_bit   <= rx_bit + BW'(1);
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                PARITY: begin
                    if (rx_cnt >= div_m1) begin
                        rx_cnt   <= '0;
                        rx_par   <= rx;
                        rx_state <= STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (rx_cnt >= div_m1) begin
                        rx_cnt          <= '0;
                        o_framing_error <= !rx;
                        o_parity_error  <= parity_en && (rx_par != ((^rx_shift) ^ parity_odd));
                        if (rx_full) o_overrun_error <= 1'b1;
                        rx_state        <= IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                       o_fifo_data_out <= '0;
        else if (o_fifo_rd_en && !o_empty) o_fifo_data_out <= rx_head;
    end
endmodule

// File: tb/tb_uart_top.sv
// tb/tb_uart_top.sv - self-checking bench for uart_top
module tb_uart_top;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] baud_divisor;
    logic [1:0]  i_parity_type;
    logic [7:0]  i_data_in;
    logic        i_wr_en;
    logic        i_full, i_almostfull, i_almostempty, i_overflow, i_underflow, i_wr_ack;
    logic        o_fifo_rd_en;
    logic [7:0]  o_fifo_data_out;
    logic        o_empty, o_almostfull, o_almostempty, o_overflow, o_underflow, o_wr_ack;
    logic        o_framing_error, o_parity_error, o_overrun_error;
    logic        baud_tick_o;
    logic        i_rx;
    logic        o_tx;

    always #5 clk = ~clk;

    uart_top #(.DATA_W(8), .FIFO_DEPTH(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .baud_divisor    (baud_divisor),
        .i_parity_type   (i_parity_type),
        .i_data_in       (i_data_in),
        .i_wr_en         (i_wr_en),
        .i_full          (i_full),
        .i_almostfull    (i_almostfull),
        .i_almostempty   (i_almostempty),
        .i_overflow      (i_overflow),
        .i_underflow     (i_underflow),
        .i_wr_ack        (i_wr_ack),
        .o_fifo_rd_en    (o_fifo_rd_en),
        .o_fifo_data_out (o_fifo_data_out),
        .o_empty         (o_empty),
        .o_almostfull    (o_almostfull),
        .o_almostempty   (o_almostempty),
        .o_overflow      (o_overflow),
        .o_underflow     (o_underflow),
        .o_wr_ack        (o_wr_ack),
        .o_framing_error (o_framing_error),
        .o_parity_error  (o_parity_error),
        .o_overrun_error (o_overrun_error),
        .baud_tick_o     (baud_tick_o),
        .i_rx            (i_rx),
        .o_tx            (o_tx)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q [$];
    logic [7:0] last_exp = '0;

    // RX write monitor: snapshot of error flags at each accepted RX write.
    int   ack_cnt = 0;
    int   ovf_cnt = 0;
    int   ack_err_cnt = 0;
    logic ack_fe = 1'b0, ack_pe = 1'b0;
    logic ack_fe_rise = 1'b0, ack_pe_rise = 1'b0;
    logic fe_d = 1'b0, pe_d = 1'b0;

    always @(negedge clk) begin
        if (o_wr_ack) begin
            ack_cnt++;
            ack_fe      = o_framing_error;
            ack_pe      = o_parity_error;
            ack_fe_rise = o_framing_error && !fe_d;
            ack_pe_rise = o_parity_error && !pe_d;
            if (o_framing_error || o_parity_error) ack_err_cnt++;
        end
        if (o_overflow) ovf_cnt++;
        fe_d = o_framing_error;
        pe_d = o_parity_error;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input logic [15:0] div, input logic [1:0] par);
        rst_n         = 1'b0;
        baud_divisor  = div;
        i_parity_type = par;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic tx_write(input logic [7:0] d);
        i_data_in = d;
        i_wr_en   = 1'b1;
        @(negedge clk);
        i_wr_en   = 1'b0;
    endtask

    task automatic read_rx(input string tag);
        int k = 0;
        while (o_empty && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_avail"}, o_empty, 0);
        if (!o_empty) begin
            o_fifo_rd_en = 1'b1;
            @(negedge clk);
            o_fifo_rd_en = 1'b0;
            check({tag, "_sb"}, exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                last_exp = exp_q.pop_front();
                check(tag, o_fifo_data_out, last_exp);
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit use_par, input bit odd,
                              input bit flip_par, input bit stop_val, input int div);
        exp_q.push_back(d);
        i_rx = 1'b0;
        repeat (div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            i_rx = d[i];
            repeat (div) @(negedge clk);
        end
        if (use_par) begin
            i_rx = (^d) ^ odd ^ flip_par;
            repeat (div) @(negedge clk);
        end
        i_rx = stop_val;
        repeat (div) @(negedge clk);
        i_rx = 1'b1;
        repeat (div) @(negedge clk);
    endtask

    task automatic measure_tick(output int period);
        int k = 0;
        while (!baud_tick_o && k < 1000) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        period = 1;
        while (!baud_tick_o && period < 1000) begin
            @(negedge clk);
            period++;
        end
    endtask

    task automatic wait_acks(input int target);
        int k = 0;
        while (ack_cnt < target && k < 5000) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         p;
        int         a0, o0, e0;
        logic [7:0] d;

        rst_n = 1'b0; baud_divisor = 16'd434; i_parity_type = 2'b00;
        i_data_in = '0; i_wr_en = 1'b0; o_fifo_rd_en = 1'b0; i_rx = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_tx", o_tx, 1);
        check("rst_empty", o_empty, 1);
        check("rst_full", i_full, 0);
        check("rst_errs", {o_framing_error, o_parity_error, o_overrun_error}, 0);
        check("rst_pulses", {i_overflow, i_wr_ack, o_overflow, o_underflow, o_wr_ack}, 0);
        check("rst_dout", o_fifo_data_out, 0);
        rst_n = 1'b1;

        // Baud tick period and divisor clamp
        measure_tick(p);
        check("tick_434", p, 434);
        baud_divisor = 16'd5;
        measure_tick(p);
        measure_tick(p);
        check("tick_clamp16", p, 16);

        // Loopback, even parity
        do_reset(16'd16, 2'b01);
        for (int i = 0; i < 7; i++) begin
            d = 8'($urandom);
            exp_q.push_back(d);
            tx_write(d);
            check("loop_wr_ack", i_wr_ack, 1);
        end
        for (int i = 0; i < 7; i++) read_rx("loop_data");
        check("loop_errs", {o_framing_error, o_parity_error, o_overrun_error}, 0);

        // TX FIFO boundaries, then RX overrun
        do_reset(16'd16, 2'b01);
        a0 = ack_cnt;
        p = 0;
        while (!baud_tick_o && p < 100) begin
            @(negedge clk);
            p++;
        end
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            exp_q.push_back(d);
            tx_write(d);
            if (i == 0) check("tx_aempty", i_almostempty, 1);
            if (i == 6) check("tx_afull", i_almostfull, 1);
        end
        check("tx_full", i_full, 1);
        check("tx_afull_off", i_almostfull, 0);
        tx_write(8'h3C);
        check("tx_ovf", i_overflow, 1);
        check("tx_noack", i_wr_ack, 0);
        wait_acks(a0 + 7);
        check("rx_afull", o_almostfull, 1);
        wait_acks(a0 + 8);
        check("rx_cnt8", ack_cnt - a0, 8);
        check("rx_afull_off", o_almostfull, 0);
        check("rx_no_overrun", o_overrun_error, 0);
        o0 = ovf_cnt;
        tx_write(8'hC3);
        p = 0;
        while (ovf_cnt == o0 && p < 5000) begin
            @(negedge clk);
            p++;
        end
        check("rx_ovf_pulse", ovf_cnt - o0, 1);
        check("overrun_set", o_overrun_error, 1);
        check("rx_keep8", ack_cnt - a0, 8);
        for (int i = 0; i < 8; i++) read_rx("ovr_data");
        check("rx_drained", o_empty, 1);
        o_fifo_rd_en = 1'b1;
        @(negedge clk);
        o_fifo_rd_en = 1'b0;
        check("rx_udf", o_underflow, 1);
        check("rx_hold", o_fifo_data_out, last_exp);
        check("overrun_sticky", o_overrun_error, 1);

        // Framing error: 0xAA, odd parity, stop bit 0
        do_reset(16'd16, 2'b10);
        send_frame(8'hAA, 1'b1, 1'b1, 1'b0, 1'b0, 16);
        check("fe_set", ack_fe, 1);
        check("fe_rise_at_ack", ack_fe_rise, 1);
        check("fe_no_pe", ack_pe, 0);
        read_rx("fe_data");

        // Parity error: 0x5A, even parity, wrong parity bit
        i_parity_type = 2'b01;
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 16);
        check("pe_set", ack_pe, 1);
        check("pe_rise_at_ack", ack_pe_rise, 1);
        check("pe_fe_clear", ack_fe, 0);
        read_rx("pe_data");

        // External burst at 434, parity code 11 = none, drained concurrently
        baud_divisor  = 16'd434;
        i_parity_type = 2'b11;
        a0 = ack_cnt;
        e0 = ack_err_cnt;
        fork
            begin
                for (int i = 0; i < 10; i++) send_frame(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b1, 434);
            end
            begin
                for (int j = 0; j < 10; j++) read_rx("burst_data");
            end
        join
        check("burst_cnt", ack_cnt - a0, 10);
        check("burst_errs", ack_err_cnt - e0, 0);
        check("burst_flags", {o_framing_error, o_parity_error, o_overrun_error}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
